// File: rtl/fcp_rx_phy.sv
// ----------------------------------------------------------------------------
// fcp_rx_phy
//   Slave-side receive PHY for the single-wire FCP link. Samples the raw line,
//   recognises pings, quarter-UI sync bursts and NRZ bytes (MSB first plus an
//   odd-parity bit) and hands decoded bytes to the slave protocol engine.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   rx_en        1 = receive enabled, 0 = held in IDLE (slave transmitting)
//   fcp_din      raw line, asynchronous to clk
//   rx_byte      last committed byte, held until the next commit
//   rx_byte_vld  1-cycle pulse: rx_byte updated
//   rx_par_err   parity mismatch flag, valid with rx_byte_vld
//   ping_det     1-cycle pulse: valid ping ended
//   frame_end    1-cycle pulse: end-of-frame ping start recognised
//   rx_err       1-cycle pulse: framing/timing error
//   rx_busy      1 while not IDLE
// ----------------------------------------------------------------------------
module fcp_rx_phy #(
  parameter int unsigned CLK_PER_UI = 160,
  parameter int unsigned PING_MIN   = 12,
  parameter int unsigned PING_MAX   = 20,
  parameter int unsigned IDLE_TO    = 40,
  parameter int unsigned CNT_W      = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       fcp_din,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       rx_par_err,
  output logic       ping_det,
  output logic       frame_end,
  output logic       rx_err,
  output logic       rx_busy
);

  // Counters are cleared to 0 in the cycle after an event, so a count of N
  // cycles is reached when the register holds N-1.
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLK_PER_UI / 2 - 1);
  localparam logic [CNT_W-1:0] UI_M1    = CNT_W'(CLK_PER_UI - 1);
  localparam logic [CNT_W-1:0] PING_LO  = CNT_W'(PING_MIN * CLK_PER_UI - 1);
  localparam logic [CNT_W-1:0] PING_HI  = CNT_W'(PING_MAX * CLK_PER_UI - 1);
  localparam logic [CNT_W-1:0] IDLE_M1  = CNT_W'(IDLE_TO * CLK_PER_UI - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PING,
    ST_WAIT_SYNC,
    ST_SYNC,
    ST_DATA,
    ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [1:0]       tap_q;
  logic             line_q, line_prev_q, line_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [1:0]       edge_cnt_q, edge_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       sr_q, sr_d;
  logic [7:0]       byte_q, byte_d;
  logic             vld_q, vld_d;
  logic             perr_q, perr_d;
  logic             ping_q, ping_d;
  logic             fend_q, fend_d;
  logic             err_q, err_d;
  logic             edge_s, fall_s;

  // Synchroniser (2 flops) followed by a 3-tap majority vote: 4 clk latency.
  assign line_d = (sync_q[1] & tap_q[0]) | (sync_q[1] & tap_q[1]) | (tap_q[0] & tap_q[1]);
  assign edge_s = line_q ^ line_prev_q;
  assign fall_s = line_prev_q & ~line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      tap_q       <= '0;
      line_q      <= 1'b0;
      line_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], fcp_din};
      tap_q       <= {tap_q[0], sync_q[1]};
      line_q      <= line_d;
      line_prev_q <= line_q;
    end
  end

  // Saturating run-length counter of cycles since the last line edge.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!rx_en || edge_s) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != '1) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    ph_cnt_d   = '0;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    byte_d     = byte_q;
    vld_d      = 1'b0;
    perr_d     = 1'b0;
    ping_d     = 1'b0;
    fend_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (edge_s && line_q) state_d = ST_PING;
      end
      ST_PING: begin
        if (fall_s) begin
          if (run_cnt_q >= PING_LO && run_cnt_q <= PING_HI) begin
            ping_d  = 1'b1;
            state_d = ST_WAIT_SYNC;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (run_cnt_q >= PING_HI) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_SYNC: begin
        if (edge_s) begin
          edge_cnt_d = 2'd1;
          state_d    = ST_SYNC;
        end else if (run_cnt_q == IDLE_M1) begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (edge_s) begin
          if (edge_cnt_q != 2'd3) edge_cnt_d = edge_cnt_q + 2'd1;
        end else if (run_cnt_q == HALF_M1) begin
          if (edge_cnt_q == 2'd3) begin
            sr_d      = {8'h00, line_q};
            bit_cnt_d = 4'd1;
            state_d   = ST_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        ph_cnt_d = ph_cnt_q + 1'b1;
        if (ph_cnt_q == UI_M1) begin
          sr_d      = {sr_q[7:0], line_q};
          ph_cnt_d  = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        ph_cnt_d = ph_cnt_q + 1'b1;
        if (edge_s) begin
          // The committing edge doubles as the first edge of the next sync.
          vld_d      = 1'b1;
          byte_d     = sr_q[8:1];
          perr_d     = (sr_q[0] != (~^sr_q[8:1]));
          edge_cnt_d = 2'd1;
          state_d    = ST_SYNC;
        end else if (ph_cnt_q == UI_M1) begin
          // run_cnt is left running so the ping width counts from the last sync edge.
          if (line_q) begin
            fend_d  = 1'b1;
            state_d = ST_PING;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rx_en) begin
      state_d    = ST_IDLE;
      edge_cnt_d = '0;
      ph_cnt_d   = '0;
      bit_cnt_d  = '0;
      byte_d     = byte_q;
      vld_d      = 1'b0;
      perr_d     = 1'b0;
      ping_d     = 1'b0;
      fend_d     = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      run_cnt_q  <= '0;
      ph_cnt_q   <= '0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      byte_q     <= '0;
      vld_q      <= 1'b0;
      perr_q     <= 1'b0;
      ping_q     <= 1'b0;
      fend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      ph_cnt_q   <= ph_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      byte_q     <= byte_d;
      vld_q      <= vld_d;
      perr_q     <= perr_d;
      ping_q     <= ping_d;
      fend_q     <= fend_d;
      err_q      <= err_d;
    end
  end

  assign rx_byte     = byte_q;
  assign rx_byte_vld = vld_q;
  assign rx_par_err  = perr_q;
  assign ping_det    = ping_q;
  assign frame_end   = fend_q;
  assign rx_err      = err_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fcp_rx_phy.sv
// ----------------------------------------------------------------------------
// tb_fcp_rx_phy
//   Directed bench for fcp_rx_phy (CLK_PER_UI=160). Drives line waveforms
//   (pings, quarter-UI sync bursts, NRZ bytes) and checks pulses, bytes and
//   parity flags against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_fcp_rx_phy;

  localparam int unsigned UI  = 160;
  localparam int unsigned QUI = UI / 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       fcp_din;
  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic       rx_par_err;
  logic       ping_det;
  logic       frame_end;
  logic       rx_err;
  logic       rx_busy;

  fcp_rx_phy #(
    .CLK_PER_UI (160),
    .PING_MIN   (12),
    .PING_MAX   (20),
    .IDLE_TO    (40),
    .CNT_W      (14)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_en       (rx_en),
    .fcp_din     (fcp_din),
    .rx_byte     (rx_byte),
    .rx_byte_vld (rx_byte_vld),
    .rx_par_err  (rx_par_err),
    .ping_det    (ping_det),
    .frame_end   (frame_end),
    .rx_err      (rx_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int unsigned n_vld = 0, n_ping = 0, n_fend = 0, n_err = 0;
  int unsigned t_vld = 0, t_ping = 0, t_fend = 0;
  logic [7:0]  cap_byte [64];
  logic        cap_perr [64];

  always @(negedge clk) begin
    if (rx_byte_vld) begin
      cap_byte[n_vld % 64] = rx_byte;
      cap_perr[n_vld % 64] = rx_par_err;
      n_vld = n_vld + 1;
      t_vld = cyc;
    end
    if (ping_det) begin
      n_ping = n_ping + 1;
      t_ping = cyc;
    end
    if (frame_end) begin
      n_fend = n_fend + 1;
      t_fend = cyc;
    end
    if (rx_err) n_err = n_err + 1;
  end

  int unsigned n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int unsigned n);
    fcp_din = v;
    repeat (n) @(negedge clk);
  endtask

  // Quarter-UI sync burst whose final level is the following bit7.
  task automatic send_sync(input logic fin);
    int unsigned n;
    n = (fcp_din == fin) ? 4 : 3;
    for (int unsigned i = 0; i < n; i++) begin
      fcp_din = ~fcp_din;
      if (i < n - 1) repeat (QUI) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic p);
    for (int i = 7; i >= 0; i--) drive(d[i], UI);
    drive(p, UI);
  endtask

  // End-of-frame: trailing sync to high, then the line stays high 16 UI from that edge.
  task automatic send_eof();
    send_sync(1'b1);
    drive(1'b1, 16 * UI);
    drive(1'b0, 10);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       exp_perr;
  } vec_t;

  vec_t        tbl [6];
  logic [7:0]  t3_exp [3];
  int unsigned s_vld, s_ping, s_fend, s_err, tf;
  logic [7:0]  d;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, required finish before 90000", cyc);
    n_bad = n_bad + 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end

  initial begin
    // data, parity bit sent, expected parity error (odd parity: par == ~^data)
    tbl[0] = '{8'h01, 1'b0, 1'b0};
    tbl[1] = '{8'h2C, 1'b1, 1'b1};
    tbl[2] = '{8'h2C, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 1'b0};
    tbl[4] = '{8'hA5, 1'b0, 1'b1};
    tbl[5] = '{8'h00, 1'b1, 1'b0};
    t3_exp[0] = 8'h0C;
    t3_exp[1] = 8'h04;
    t3_exp[2] = 8'hE2;

    rst = 1'b1; rx_en = 1'b1; fcp_din = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rx_byte, rx_byte_vld, rx_par_err, ping_det, frame_end, rx_err, rx_busy}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Valid 16 UI ping, latency, then natural WAIT_SYNC timeout.
    s_ping = n_ping; s_err = n_err;
    drive(1'b1, 16 * UI);
    fcp_din = 1'b0;
    tf = cyc;
    repeat (10) @(negedge clk);
    chk("ping_count", n_ping - s_ping, 1);
    chk("ping_latency", t_ping - tf, 5);
    chk("ping_busy", rx_busy, 1);
    drive(1'b0, 41 * UI);
    chk("wait_sync_timeout_busy", rx_busy, 0);
    chk("wait_sync_timeout_err", n_err - s_err, 0);

    // Short ping (8 UI) -> error.
    s_ping = n_ping; s_err = n_err;
    drive(1'b1, 8 * UI);
    drive(1'b0, 10);
    chk("short_ping_err", n_err - s_err, 1);
    chk("short_ping_det", n_ping - s_ping, 0);

    // Over-long high (21 UI) -> error while still high.
    s_ping = n_ping; s_err = n_err;
    drive(1'b1, 21 * UI);
    chk("long_ping_err", n_err - s_err, 1);
    chk("long_ping_busy", rx_busy, 0);
    drive(1'b0, 10);
    chk("long_ping_det", n_ping - s_ping, 0);
    chk("long_ping_err_once", n_err - s_err, 1);

    // Single-byte frames chained through WAIT_SYNC.
    drive(1'b1, 16 * UI);
    drive(1'b0, 10);
    for (int unsigned i = 0; i < 6; i++) begin
      s_vld = n_vld; s_ping = n_ping; s_fend = n_fend; s_err = n_err;
      drive(1'b0, (i == 0) ? (25 * UI - 10) : (3 * UI));
      send_sync(tbl[i].data[7]);
      send_byte(tbl[i].data, tbl[i].par);
      send_eof();
      chk("tbl_vld_count", n_vld - s_vld, 1);
      chk("tbl_byte", cap_byte[s_vld % 64], tbl[i].data);
      chk("tbl_par_err", cap_perr[s_vld % 64], tbl[i].exp_perr);
      chk("tbl_frame_end", n_fend - s_fend, 1);
      chk("tbl_ping_det", n_ping - s_ping, 1);
      chk("tbl_rx_err", n_err - s_err, 0);
      chk("tbl_order_vld_fend", t_vld < t_fend, 1);
      chk("tbl_order_fend_ping", t_fend < t_ping, 1);
    end

    // Three-byte frame 0x0C, 0x04, 0xE2.
    s_vld = n_vld; s_fend = n_fend; s_err = n_err;
    drive(1'b0, 3 * UI);
    send_sync(1'b0); send_byte(8'h0C, 1'b1);
    send_sync(1'b0); send_byte(8'h04, 1'b0);
    send_sync(1'b1); send_byte(8'hE2, 1'b1);
    send_eof();
    chk("multi_vld_count", n_vld - s_vld, 3);
    for (int unsigned k = 0; k < 3; k++) begin
      chk("multi_byte", cap_byte[(s_vld + k) % 64], t3_exp[k]);
      chk("multi_par_err", cap_perr[(s_vld + k) % 64], 0);
    end
    chk("multi_rx_err", n_err - s_err, 0);
    chk("multi_frame_end", n_fend - s_fend, 1);

    // Mid-frame 0xFF with parity 1 followed by a sync.
    s_vld = n_vld; s_fend = n_fend; s_err = n_err;
    drive(1'b0, 3 * UI);
    send_sync(1'b1); send_byte(8'hFF, 1'b1);
    send_sync(1'b1); send_byte(8'hE2, 1'b1);
    chk("ff_mid_vld", n_vld - s_vld, 1);
    chk("ff_mid_byte", cap_byte[s_vld % 64], 8'hFF);
    chk("ff_mid_no_fend", n_fend - s_fend, 0);
    send_eof();
    chk("ff_end_vld", n_vld - s_vld, 2);
    chk("ff_end_byte", cap_byte[(s_vld + 1) % 64], 8'hE2);
    chk("ff_end_fend", n_fend - s_fend, 1);
    chk("ff_end_err", n_err - s_err, 0);

    // rx_en dropped mid-byte.
    s_vld = n_vld; s_ping = n_ping; s_fend = n_fend; s_err = n_err;
    drive(1'b0, 3 * UI);
    send_sync(1'b0);
    d = 8'h0C;
    for (int i = 7; i >= 4; i--) drive(d[i], UI);
    chk("rxen_busy_before", rx_busy, 1);
    rx_en = 1'b0;
    @(negedge clk);
    chk("rxen_busy_after", rx_busy, 0);
    for (int i = 3; i >= 0; i--) drive(d[i], UI);
    drive(1'b1, UI);
    drive(1'b0, 20);
    rx_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("rxen_no_vld", n_vld - s_vld, 0);
    chk("rxen_no_pulses", (n_ping - s_ping) + (n_fend - s_fend) + (n_err - s_err), 0);
    chk("rxen_byte_held", rx_byte, 8'hE2);
    chk("rxen_idle", rx_busy, 0);

    // Asynchronous reset mid-byte.
    drive(1'b1, 16 * UI);
    drive(1'b0, 3 * UI);
    s_vld = n_vld;
    send_sync(1'b1);
    d = 8'hA5;
    for (int i = 7; i >= 4; i--) drive(d[i], UI);
    drive(1'b0, 60);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs",
           {rx_byte, rx_byte_vld, rx_par_err, ping_det, frame_end, rx_err, rx_busy}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("reset_no_vld", n_vld - s_vld, 0);
    chk("reset_idle", rx_busy, 0);
    chk("reset_byte_cleared", rx_byte, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
